// File: rtl/data_memory.sv
// ============================================================================
// Module   : data_memory
// Purpose  : Word-addressed data memory with wait-state handshake and checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_memory #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err
);

  localparam int         C_AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_wait;
  logic [C_AW-1:0]   r_idx;
  logic [31:0]       r_wdata;
  logic              r_is_write;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic w_req;
  logic w_misaligned;
  logic w_out_of_range;
  logic w_conflict;
  logic w_reject;
  logic w_access;
  logic w_mem_we;

  // Request screening uses the live inputs; it only matters on the IDLE capture edge.
  assign w_req          = memread | memwrite;
  assign w_misaligned   = |addr[1:0];
  assign w_out_of_range = |addr[31:C_AW+2];
  assign w_conflict     = memread & memwrite;
  assign w_reject       = w_misaligned | w_out_of_range | w_conflict;

  assign w_access = (r_state == BUSY) && (r_wait == 4'd0);
  assign w_mem_we = w_access & r_is_write & ~reset;

  // Array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait     <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'h0;
      r_is_write <= 1'b0;
      readdata   <= 32'h0;
      ready      <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (w_req) begin
            r_idx      <= addr[C_AW+1:2];
            r_wdata    <= writedata;
            r_is_write <= memwrite;
            if (w_reject) begin
              r_state <= DONE;
              ready   <= 1'b1;
              err     <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_wait  <= C_WAIT_LOAD;
            end
          end
        end
        BUSY: begin
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            if (!r_is_write) begin
              readdata <= r_mem[r_idx];
            end
            r_state <= DONE;
            ready   <= 1'b1;
            err     <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          ready   <= 1'b0;
          err     <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          ready   <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Directed self-checking bench for data_memory (2 and 0 wait states).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0, memwrite = 1'b0;
  logic [31:0] addr = 32'h0, writedata = 32'h0;
  logic [31:0] readdata;
  logic        ready, err;

  logic        memread0 = 1'b0, memwrite0 = 1'b0;
  logic [31:0] addr0 = 32'h0, writedata0 = 32'h0;
  logic [31:0] readdata0;
  logic        ready0, err0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .ready(ready), .err(err)
  );

  data_memory #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .memread(memread0), .memwrite(memwrite0),
    .addr(addr0), .writedata(writedata0), .readdata(readdata0),
    .ready(ready0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on the 2-wait-state instance and check the completion cycle.
  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_edges, input logic exp_err,
                     input logic [31:0] exp_rd);
    int n;
    n = 0;
    memread = rd; memwrite = wr; addr = a; writedata = wd;
    do begin
      @(posedge clk); #1;
      n++;
      if (!ready) chk({tag, "_err_idle"}, {31'b0, err}, 32'h0);
    end while (!ready && n < 30);
    chk({tag, "_latency"}, 32'(n), 32'(exp_edges));
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_readdata"}, readdata, exp_rd);
    memread = 1'b0; memwrite = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_drop"}, {31'b0, ready}, 32'h0);
  endtask

  task automatic load0(input string tag, input logic [31:0] a, input logic [31:0] exp_rd);
    int n;
    n = 0;
    memread0 = 1'b1; addr0 = a;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready0 && n < 30);
    chk({tag, "_latency"}, 32'(n), 32'd2);
    chk({tag, "_err"}, {31'b0, err0}, 32'h0);
    chk({tag, "_readdata"}, readdata0, exp_rd);
    memread0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, second;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Store then load at 0x10: valid latency is WAIT_STATES+2 edges
    txn("st_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4, 1'b0, 32'h0);
    txn("ld_10", 1'b1, 1'b0, 32'h10, 32'h0, 4, 1'b0, 32'hDEADBEEF);

    // Rejections complete on the edge after capture with readdata untouched
    txn("ld_misalign", 1'b1, 1'b0, 32'h12, 32'h0, 1, 1'b1, 32'hDEADBEEF);
    txn("ld_range", 1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'hDEADBEEF);

    // Conflicting read+write must not touch the array
    txn("st_4", 1'b0, 1'b1, 32'h4, 32'hA5A50004, 4, 1'b0, 32'hDEADBEEF);
    txn("both_4", 1'b1, 1'b1, 32'h4, 32'hFFFFFFFF, 1, 1'b1, 32'hDEADBEEF);
    txn("ld_4", 1'b1, 1'b0, 32'h4, 32'h0, 4, 1'b0, 32'hA5A50004);

    // Reset on the access edge suppresses the store
    txn("st_8", 1'b0, 1'b1, 32'h8, 32'h0BADF00D, 4, 1'b0, 32'hA5A50004);
    memwrite = 1'b1; addr = 32'h8; writedata = 32'h12345678;
    @(posedge clk); #1;
    memwrite = 1'b0;
    chk("st_8_rst_busy", {31'b0, ready}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("st_8_rst_ready", {31'b0, ready}, 32'h0);
    chk("st_8_rst_err", {31'b0, err}, 32'h0);
    chk("st_8_rst_readdata", readdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    txn("ld_8", 1'b1, 1'b0, 32'h8, 32'h0, 4, 1'b0, 32'h0BADF00D);

    // Zero wait states, request held high across two stores
    first = -1; second = -1;
    memwrite0 = 1'b1; addr0 = 32'h0; writedata0 = 32'h11111111;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ready0) begin
        chk("ws0_err", {31'b0, err0}, 32'h0);
        if (first < 0) begin
          first = n;
          addr0 = 32'h4; writedata0 = 32'h22222222;
        end else begin
          second = n;
          break;
        end
      end
    end
    memwrite0 = 1'b0;
    chk("ws0_first", 32'(first), 32'd2);
    chk("ws0_gap", 32'(second - first), 32'd3);
    @(posedge clk); #1;
    load0("ws0_ld_4", 32'h4, 32'h22222222);
    load0("ws0_ld_0", 32'h0, 32'h11111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
